// File: rtl/maindec_multicycle.sv
// ---------------------------------------------------------------------------
// maindec_multicycle
//   Multi-cycle LEGv8 main decoder. Each instruction is sequenced through
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and back to FETCH. Undefined
//   opcodes, external interrupts and memory timeouts divert to an EXC state
//   that pulses Exc for one cycle and records the cause in EStatus.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low; every output except state_o is
//                   forced to 0 while low
//   Op         in   opcode from the instruction register (used in DECODE)
//   ExtIRQ     in   level interrupt request, sampled in DECODE only
//   mem_ready  in   memory access complete
//   IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead,
//   MemWrite, Branch, ERet, Exc   out  datapath strobes
//   ALUOp      out  00 add, 01 pass-B/zero test, 10 R-type funct
//   EStatus    out  latched exception cause (1 IRQ, 2 undef, 3 mem timeout)
//   state_o    out  registered state encoding, debug
//
// Memory handshake: a memory request is presented (MemRead or MemWrite
// high) for as long as the FSM sits in FETCH or MEM; the access completes
// in the cycle where mem_ready is sampled high on the rising edge. There is
// no separate request/valid wire -- the strobe itself is the request, and
// mem_ready outside FETCH/MEM is ignored.
// ---------------------------------------------------------------------------
module maindec_multicycle #(
  parameter int OP_W        = 11,
  parameter int ALUOP_W     = 2,
  parameter int ECODE_W     = 4,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    Op,
  input  logic               ExtIRQ,
  input  logic               mem_ready,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               Reg2Loc,
  output logic               ALUSrc,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               Branch,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ERet,
  output logic               Exc,
  output logic [ECODE_W-1:0] EStatus,
  output logic [2:0]         state_o
);

  // State encodings (6 and 7 are illegal and fall back to FETCH)
  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_EXC    = 3'd5;

  // Latched opcode classes
  localparam logic [2:0] CLS_NONE  = 3'd0;
  localparam logic [2:0] CLS_R     = 3'd1;
  localparam logic [2:0] CLS_LDUR  = 3'd2;
  localparam logic [2:0] CLS_STUR  = 3'd3;
  localparam logic [2:0] CLS_CBZ   = 3'd4;
  localparam logic [2:0] CLS_ERET  = 3'd5;
  localparam logic [2:0] CLS_MRS   = 3'd6;
  localparam logic [2:0] CLS_UNDEF = 3'd7;

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [ECODE_W-1:0] CAUSE_IRQ     = ECODE_W'(1);
  localparam logic [ECODE_W-1:0] CAUSE_UNDEF   = ECODE_W'(2);
  localparam logic [ECODE_W-1:0] CAUSE_TIMEOUT = ECODE_W'(3);

  logic [2:0]         state_q, state_d;
  logic [2:0]         cls_q, cls_d;
  logic [2:0]         dec_cls;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ECODE_W-1:0] estatus_q, estatus_d;
  logic [10:0]        op11;
  logic [1:0]         aluop2;

  // Decode always looks at the top 11 opcode bits; narrower opcodes are
  // left-aligned and padded with zeros.
  generate
    if (OP_W >= 11) begin : g_op_wide
      assign op11 = Op[OP_W-1 -: 11];
    end else begin : g_op_narrow
      assign op11 = {Op, {(11 - OP_W){1'b0}}};
    end
  endgenerate

  // Opcode classification. A plain case (not casez) is used so that any
  // X/Z bit fails every item and lands in UNDEF; the CBZ don't-care bits
  // are therefore spelled out explicitly.
  always_comb begin
    dec_cls = CLS_UNDEF;
    case (op11)
      11'b10001011000, 11'b11001011000,
      11'b10001010000, 11'b10101010000: dec_cls = CLS_R;
      11'b11111000010:                  dec_cls = CLS_LDUR;
      11'b11111000000:                  dec_cls = CLS_STUR;
      11'b10110100000, 11'b10110100001,
      11'b10110100010, 11'b10110100011,
      11'b10110100100, 11'b10110100101,
      11'b10110100110, 11'b10110100111: dec_cls = CLS_CBZ;
      11'b11010110100:                  dec_cls = CLS_ERET;
      11'b11010101001:                  dec_cls = CLS_MRS;
      default:                          dec_cls = CLS_UNDEF;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = cnt_q;
    estatus_d = estatus_q;
    case (state_q)
      ST_FETCH: begin
        // Instruction fetch waits indefinitely; no timeout here.
        if (mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        if (ExtIRQ) begin
          state_d   = ST_EXC;
          estatus_d = CAUSE_IRQ;
        end else if (dec_cls == CLS_UNDEF) begin
          state_d   = ST_EXC;
          estatus_d = CAUSE_UNDEF;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (cls_q)
          CLS_R, CLS_MRS:       state_d = ST_WB;
          CLS_LDUR, CLS_STUR:   state_d = ST_MEM;
          default:              state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (cls_q != CLS_LDUR && cls_q != CLS_STUR) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end else if (mem_ready) begin
          // Success wins even in the last allowed cycle.
          state_d = (cls_q == CLS_LDUR) ? ST_WB : ST_FETCH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_EXC;
          estatus_d = CAUSE_TIMEOUT;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_EXC:  state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  // EStatus is loaded on the edge entering EXC so the new cause is already
  // visible during the Exc pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= CLS_NONE;
      cnt_q     <= '0;
      estatus_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      estatus_q <= estatus_d;
    end
  end

  // Moore outputs from registered state and latched class. The only
  // exception is the FETCH completion strobes, which follow mem_ready.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ERet     = 1'b0;
    Exc      = 1'b0;
    aluop2   = 2'b00;
    if (reset) begin
      case (state_q)
        ST_FETCH: begin
          MemRead = 1'b1;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        ST_EXEC: begin
          case (cls_q)
            CLS_R:    aluop2 = 2'b10;
            CLS_LDUR: ALUSrc = 1'b1;
            CLS_STUR: begin
              ALUSrc  = 1'b1;
              Reg2Loc = 1'b1;
            end
            CLS_CBZ: begin
              Reg2Loc = 1'b1;
              Branch  = 1'b1;
              aluop2  = 2'b01;
            end
            CLS_ERET: begin
              ERet    = 1'b1;
              PCWrite = 1'b1;
            end
            CLS_MRS:  aluop2 = 2'b01;
            default:  aluop2 = 2'b00;
          endcase
        end
        ST_MEM: begin
          if (cls_q == CLS_LDUR) begin
            MemRead = 1'b1;
            ALUSrc  = 1'b1;
          end else if (cls_q == CLS_STUR) begin
            MemWrite = 1'b1;
            ALUSrc   = 1'b1;
            Reg2Loc  = 1'b1;
          end
        end
        ST_WB: begin
          RegWrite = 1'b1;
          MemtoReg = (cls_q == CLS_LDUR);
        end
        ST_EXC: begin
          Exc     = 1'b1;
          PCWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ALUOp   = ALUOP_W'(aluop2);
  assign EStatus = reset ? estatus_q : '0;
  assign state_o = state_q;

endmodule

// File: tb/tb_maindec_multicycle.sv
// ---------------------------------------------------------------------------
// tb_maindec_multicycle
//   Self-checking bench. A transaction-level model turns each instruction
//   (opcode, interrupt flag, fetch wait, memory wait) into a per-cycle list
//   of stimulus and expected output vectors; the tests replay those lists
//   against the decoder cycle by cycle.
// ---------------------------------------------------------------------------
module tb_maindec_multicycle;

  localparam int TO = 8;

  // Expected/observed vector layout (20 bits):
  //   [19:17] state  16 IRWrite  15 PCWrite  14 Reg2Loc  13 ALUSrc
  //   12 MemtoReg  11 RegWrite  10 MemRead  9 MemWrite  8 Branch
  //   [7:6] ALUOp  5 ERet  4 Exc  [3:0] EStatus
  localparam logic [19:0] F_IRW = 20'd1 << 16;
  localparam logic [19:0] F_PCW = 20'd1 << 15;
  localparam logic [19:0] F_R2L = 20'd1 << 14;
  localparam logic [19:0] F_ALS = 20'd1 << 13;
  localparam logic [19:0] F_M2R = 20'd1 << 12;
  localparam logic [19:0] F_RW  = 20'd1 << 11;
  localparam logic [19:0] F_MR  = 20'd1 << 10;
  localparam logic [19:0] F_MW  = 20'd1 << 9;
  localparam logic [19:0] F_BR  = 20'd1 << 8;
  localparam logic [19:0] F_ERT = 20'd1 << 5;
  localparam logic [19:0] F_EXC = 20'd1 << 4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100101;
  localparam logic [10:0] OP_ERET = 11'b11010110100;
  localparam logic [10:0] OP_MRS  = 11'b11010101001;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_ERET = 4,
                 C_MRS = 5, C_UNDEF = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] Op;
  logic        ExtIRQ;
  logic        mem_ready;
  logic        IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, ERet, Exc;
  logic [1:0]  ALUOp;
  logic [3:0]  EStatus;
  logic [2:0]  state_o;

  int          checks = 0;
  int          errors = 0;
  logic [3:0]  model_est;
  logic [19:0] exp_q[$];
  logic [12:0] drv_q[$];

  maindec_multicycle #(
    .OP_W(11), .ALUOP_W(2), .ECODE_W(4), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .Op(Op), .ExtIRQ(ExtIRQ), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp), .ERet(ERet),
    .Exc(Exc), .EStatus(EStatus), .state_o(state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic [19:0] ev(input logic [2:0] st, input logic [19:0] fl,
                                     input logic [1:0] al, input logic [3:0] es);
    logic [19:0] v;
    v = fl;
    v[19:17] = st;
    v[7:6]   = al;
    v[3:0]   = es;
    return v;
  endfunction

  function automatic int classify(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return C_R;
    if (op == OP_LDUR) return C_LD;
    if (op == OP_STUR) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op == OP_ERET) return C_ERET;
    if (op == OP_MRS) return C_MRS;
    return C_UNDEF;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [10:0] rop();
    return 11'($urandom_range(0, 2047));
  endfunction

  function automatic logic [19:0] pack();
    return {state_o, IRWrite, PCWrite, Reg2Loc, ALUSrc, MemtoReg, RegWrite,
            MemRead, MemWrite, Branch, ALUOp, ERet, Exc, EStatus};
  endfunction

  task automatic push(input logic [10:0] op, input logic mr, input logic irq,
                      input logic [19:0] e);
    drv_q.push_back({op, mr, irq});
    exp_q.push_back(e);
  endtask

  // Expands one instruction into its cycle-by-cycle expectations. Op is held
  // through FETCH/DECODE and scrambled afterwards; ExtIRQ and mem_ready are
  // random wherever the decoder must ignore them.
  task automatic build_instr(input logic [10:0] op, input logic irq,
                             input int fwait, input int mwait);
    int c;
    c = classify(op);
    for (int i = 0; i < fwait; i++) push(op, 1'b0, rb(), ev(3'd0, F_MR, 2'd0, model_est));
    push(op, 1'b1, rb(), ev(3'd0, F_IRW | F_PCW | F_MR, 2'd0, model_est));
    push(op, rb(), irq, ev(3'd1, 20'd0, 2'd0, model_est));
    if (irq || c == C_UNDEF) begin
      model_est = irq ? 4'd1 : 4'd2;
      push(rop(), rb(), rb(), ev(3'd5, F_PCW | F_EXC, 2'd0, model_est));
      return;
    end
    case (c)
      C_R: begin
        push(rop(), rb(), rb(), ev(3'd2, 20'd0, 2'd2, model_est));
        push(rop(), rb(), rb(), ev(3'd4, F_RW, 2'd0, model_est));
      end
      C_MRS: begin
        push(rop(), rb(), rb(), ev(3'd2, 20'd0, 2'd1, model_est));
        push(rop(), rb(), rb(), ev(3'd4, F_RW, 2'd0, model_est));
      end
      C_CBZ:  push(rop(), rb(), rb(), ev(3'd2, F_R2L | F_BR, 2'd1, model_est));
      C_ERET: push(rop(), rb(), rb(), ev(3'd2, F_ERT | F_PCW, 2'd0, model_est));
      default: begin
        logic [19:0] mf;
        mf = (c == C_LD) ? (F_MR | F_ALS) : (F_MW | F_ALS | F_R2L);
        push(rop(), rb(), rb(), ev(3'd2, (c == C_ST) ? (F_ALS | F_R2L) : F_ALS,
                                   2'd0, model_est));
        if (mwait >= TO) begin
          for (int i = 0; i < TO; i++) push(rop(), 1'b0, rb(), ev(3'd3, mf, 2'd0, model_est));
          model_est = 4'd3;
          push(rop(), rb(), rb(), ev(3'd5, F_PCW | F_EXC, 2'd0, model_est));
        end else begin
          for (int i = 0; i < mwait; i++) push(rop(), 1'b0, rb(), ev(3'd3, mf, 2'd0, model_est));
          push(rop(), 1'b1, rb(), ev(3'd3, mf, 2'd0, model_est));
          if (c == C_LD) push(rop(), rb(), rb(), ev(3'd4, F_RW | F_M2R, 2'd0, model_est));
        end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge: drives one cycle of inputs, samples the
  // outputs at the falling edge, then advances past the next rising edge.
  task automatic step(input logic [12:0] d, output logic [19:0] g);
    {Op, mem_ready, ExtIRQ} = d;
    @(negedge clk);
    g = pack();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [19:0] got;
    reset = 1'b0; Op = OP_ADD; ExtIRQ = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      step({OP_ADD, 1'b1, rb()}, got);
      checks++;
      if (got !== 20'd0) begin
        errors++;
        $display("FAIL reset cyc%0d got=%h exp=%h", i, got, 20'd0);
      end
    end
    reset = 1'b1;
    model_est = 4'd0;
  endtask

  task automatic run_queue(input string name);
    logic [19:0] got, e;
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0) begin
      step(drv_q.pop_front(), got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s cyc%0d got=%h exp=%h", name, cyc, got, e);
      end
      cyc++;
    end
  endtask

  task automatic test_r_type();
    build_instr(OP_ADD, 1'b0, 0, 0);
    build_instr(OP_SUB, 1'b0, 2, 0);
    build_instr(OP_AND, 1'b0, 0, 0);
    build_instr(OP_ORR, 1'b0, 1, 0);
    build_instr(OP_MRS, 1'b0, 0, 0);
    run_queue("r_type");
  endtask

  task automatic test_ldur();
    build_instr(OP_LDUR, 1'b0, 0, 3);
    build_instr(OP_LDUR, 1'b0, 1, 0);
    run_queue("ldur");
  endtask

  task automatic test_stur_timeout();
    build_instr(OP_STUR, 1'b0, 0, TO);
    build_instr(OP_STUR, 1'b0, 0, TO - 1);
    build_instr(OP_LDUR, 1'b0, 0, TO + 3);
    run_queue("stur_timeout");
  endtask

  task automatic test_undef_irq();
    build_instr(11'b11111111111, 1'b0, 0, 0);
    build_instr(11'b11111111111, 1'b1, 0, 0);
    build_instr(OP_ADD, 1'b1, 1, 0);
    build_instr(11'b00000000000, 1'b0, 0, 0);
    run_queue("undef_irq");
  endtask

  task automatic test_cbz_eret();
    build_instr(OP_CBZ, 1'b0, 0, 0);
    build_instr(11'b10110100000, 1'b0, 0, 0);
    build_instr(OP_ERET, 1'b0, 1, 0);
    run_queue("cbz_eret");
  endtask

  task automatic test_random();
    logic [10:0] op;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 10))
        0: op = OP_ADD;
        1: op = OP_SUB;
        2: op = OP_AND;
        3: op = OP_ORR;
        4: op = OP_LDUR;
        5: op = OP_STUR;
        6: op = {8'b10110100, 3'($urandom_range(0, 7))};
        7: op = OP_ERET;
        8: op = OP_MRS;
        default: op = rop();
      endcase
      build_instr(op, ($urandom_range(0, 7) == 0), $urandom_range(0, 2),
                  $urandom_range(0, TO + 1));
    end
    run_queue("random");
  endtask

  task automatic test_reset_mid_mem();
    logic [19:0] got, e;
    build_instr(OP_STUR, 1'b0, 0, 5);
    // FETCH, DECODE, EXEC, first MEM cycle
    for (int i = 0; i < 4; i++) begin
      step(drv_q.pop_front(), got);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL reset_mid_mem pre cyc%0d got=%h exp=%h", i, got, e);
      end
    end
    exp_q.delete();
    drv_q.delete();
    // Second MEM cycle under reset: state still MEM, every strobe low.
    reset = 1'b0;
    step({OP_STUR, 1'b0, 1'b0}, got);
    checks++;
    if (got !== ev(3'd3, 20'd0, 2'd0, 4'd0)) begin
      errors++;
      $display("FAIL reset_mid_mem rst got=%h exp=%h", got, ev(3'd3, 20'd0, 2'd0, 4'd0));
    end
    reset = 1'b1;
    model_est = 4'd0;
    build_instr(OP_ADD, 1'b0, 0, 0);
    run_queue("reset_mid_mem post");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_r_type();
    test_ldur();
    test_stur_timeout();
    test_undef_irq();
    test_cbz_eret();
    test_random();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
